// File: rtl/apb_req_fifo_p.sv
// Request FIFO between the APB slave port and the round-robin arbiter.
// Stores {write flag, address, write data} per entry; head is first-word-fall-through.
module apb_req_fifo_p #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_LVL = 6,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_in,
  input  logic              push_write_in,
  input  logic [ADDR_W-1:0] push_addr_in,
  input  logic [DATA_W-1:0] push_wdata_in,
  output logic              push_ack_o,
  output logic              full_o,
  output logic              almost_full_o,
  input  logic              pop_in,
  output logic              pop_valid_o,
  output logic              pop_write_o,
  output logic [ADDR_W-1:0] pop_addr_o,
  output logic [DATA_W-1:0] pop_wdata_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              clr_err_in
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              wr_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_acc, pop_acc;

  assign push_acc = push_in & ~full_q;
  assign pop_acc  = pop_in & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc) count_d = count_q + CNT_W'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CNT_W'(1);

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    afull_d = (count_d >= CNT_W'(AFULL_LVL));

    // A new error event takes priority over a clear in the same cycle.
    ovf_d = ovf_q;
    if (push_in && full_q) ovf_d = 1'b1;
    else if (clr_err_in) ovf_d = 1'b0;

    unf_d = unf_q;
    if (pop_in && empty_q) unf_d = 1'b1;
    else if (clr_err_in) unf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is intentionally left unreset; the head mux masks it while empty.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      wr_mem[wr_ptr_q]   <= push_write_in;
      addr_mem[wr_ptr_q] <= push_addr_in;
      data_mem[wr_ptr_q] <= push_wdata_in;
    end
  end

  assign push_ack_o    = push_acc;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = afull_q;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;
  assign pop_valid_o   = ~empty_q;

  assign pop_write_o = ~empty_q & wr_mem[rd_ptr_q];
  assign pop_addr_o  = empty_q ? '0 : addr_mem[rd_ptr_q];
  assign pop_wdata_o = pop_write_o ? data_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_apb_req_fifo_p.sv
// Bench for apb_req_fifo_p: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_apb_req_fifo_p;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_in, push_write_in, pop_in, clr_err_in;
  logic [31:0] push_addr_in, push_wdata_in;
  logic        push_ack_o, full_o, almost_full_o, pop_valid_o, pop_write_o;
  logic        empty_o, overflow_o, underflow_o;
  logic [31:0] pop_addr_o, pop_wdata_o;
  logic [CW-1:0] count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_req_fifo_p #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .AFULL_LVL(AF)) dut (
    .clk(clk), .reset(reset),
    .push_in(push_in), .push_write_in(push_write_in),
    .push_addr_in(push_addr_in), .push_wdata_in(push_wdata_in),
    .push_ack_o(push_ack_o), .full_o(full_o), .almost_full_o(almost_full_o),
    .pop_in(pop_in), .pop_valid_o(pop_valid_o), .pop_write_o(pop_write_o),
    .pop_addr_o(pop_addr_o), .pop_wdata_o(pop_wdata_o),
    .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .clr_err_in(clr_err_in)
  );

  typedef struct {
    logic        rst_n, push, pw;
    logic [31:0] addr, wdata;
    logic        pop, clr;
    logic        e_ack;
    int          e_cnt;
    logic        e_empty, e_full, e_af, e_ovf, e_unf, e_pw;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  typedef struct {
    logic        w;
    logic [31:0] a, d;
  } ent_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic pw, input logic [31:0] a,
                       input logic [31:0] d, input logic po, input logic cl);
    reset = r; push_in = p; push_write_in = pw; push_addr_in = a;
    push_wdata_in = d; pop_in = po; clr_err_in = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int cnt, input logic emp, input logic ful,
                           input logic af, input logic ov, input logic un);
    chk({nm, ".count"}, 64'(count_o), 64'(cnt));
    chk({nm, ".empty"}, 64'(empty_o), 64'(emp));
    chk({nm, ".full"},  64'(full_o),  64'(ful));
    chk({nm, ".afull"}, 64'(almost_full_o), 64'(af));
    chk({nm, ".ovf"},   64'(overflow_o),  64'(ov));
    chk({nm, ".unf"},   64'(underflow_o), 64'(un));
    chk({nm, ".valid"}, 64'(pop_valid_o), 64'(!emp));
  endtask

  task automatic chk_head(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d);
    chk({nm, ".pw"},    64'(pop_write_o), 64'(w));
    chk({nm, ".paddr"}, 64'(pop_addr_o),  64'(a));
    chk({nm, ".pdata"}, 64'(pop_wdata_o), 64'(d));
  endtask

  vec_t vt[13];
  ent_t mq[$];

  initial begin
    // rst push pw addr wdata pop clr | ack cnt emp ful af ovf unf pw addr wdata
    vt[0]  = '{0,0,0,32'h0,  32'h0,   0,0, 0,0,1,0,0,0,0, 0,32'h0,  32'h0};
    vt[1]  = '{1,0,0,32'h0,  32'h0,   1,0, 0,0,1,0,0,0,1, 0,32'h0,  32'h0};
    vt[2]  = '{1,0,0,32'h0,  32'h0,   0,1, 0,0,1,0,0,0,0, 0,32'h0,  32'h0};
    vt[3]  = '{1,1,0,32'h200,32'h55,  0,0, 1,1,0,0,0,0,0, 0,32'h200,32'h0};
    vt[4]  = '{1,1,1,32'h204,32'hDEAD,0,0, 1,2,0,0,0,0,0, 0,32'h200,32'h0};
    vt[5]  = '{1,1,0,32'h208,32'h77,  0,0, 1,3,0,0,0,0,0, 0,32'h200,32'h0};
    vt[6]  = '{1,0,0,32'h0,  32'h0,   1,0, 0,2,0,0,0,0,0, 1,32'h204,32'hDEAD};
    vt[7]  = '{1,0,0,32'h0,  32'h0,   1,0, 0,1,0,0,0,0,0, 0,32'h208,32'h0};
    vt[8]  = '{1,0,0,32'h0,  32'h0,   1,0, 0,0,1,0,0,0,0, 0,32'h0,  32'h0};
    vt[9]  = '{1,1,1,32'h300,32'h1234,1,0, 1,1,0,0,0,0,1, 1,32'h300,32'h1234};
    vt[10] = '{1,0,0,32'h0,  32'h0,   1,1, 0,0,1,0,0,0,0, 0,32'h0,  32'h0};
    vt[11] = '{1,0,0,32'h0,  32'h0,   1,1, 0,0,1,0,0,0,1, 0,32'h0,  32'h0};
    vt[12] = '{0,0,0,32'h0,  32'h0,   0,0, 0,0,1,0,0,0,0, 0,32'h0,  32'h0};

    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_state("reset", 0, 1, 0, 0, 0, 0);
    chk_head("reset", 0, 0, 0);

    // Vector table: reset, error set/clear, mixed read/write traffic
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst_n, vt[i].push, vt[i].pw, vt[i].addr, vt[i].wdata, vt[i].pop, vt[i].clr);
      #1;
      chk($sformatf("vec%0d.ack", i), 64'(push_ack_o), 64'(vt[i].e_ack));
      tick();
      chk_state($sformatf("vec%0d", i), vt[i].e_cnt, vt[i].e_empty, vt[i].e_full,
                vt[i].e_af, vt[i].e_ovf, vt[i].e_unf);
      chk_head($sformatf("vec%0d", i), vt[i].e_pw, vt[i].e_addr, vt[i].e_wdata);
    end

    // Fill to full, then overflow
    for (int i = 0; i < D; i++) begin
      drive(1, 1, 1, 32'h100 + 4 * i, 32'hA0 + i, 0, 0);
      #1 chk($sformatf("fill%0d.ack", i), 64'(push_ack_o), 64'd1);
      tick();
      chk_state($sformatf("fill%0d", i), i + 1, 0, (i + 1) == D, (i + 1) >= AF, 0, 0);
      chk_head($sformatf("fill%0d", i), 1, 32'h100, 32'hA0);
    end
    drive(1, 1, 1, 32'h999, 32'h999, 0, 0);
    #1 chk("ovf.ack", 64'(push_ack_o), 64'd0);
    tick();
    chk_state("ovf", D, 0, 1, 1, 1, 0);

    // Drain in order, then underflow and clear
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      #1 chk_head($sformatf("drain%0d", i), 1, 32'h100 + 4 * i, 32'hA0 + i);
      tick();
      chk_state($sformatf("drain%0d", i), D - 1 - i, i == D - 1, 0, (D - 1 - i) >= AF, 1, 0);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    tick();
    chk_state("unf", 0, 1, 0, 0, 1, 1);
    chk_head("unf", 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    tick();
    chk_state("clr", 0, 1, 0, 0, 0, 0);

    // Steady-state push+pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h400 + i, 32'h4000 + i, 0, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 32'h400 + i + 3, 32'h4000 + i + 3, 1, 0);
      #1 chk($sformatf("wrap%0d.ack", i), 64'(push_ack_o), 64'd1);
      chk_head($sformatf("wrap%0d", i), 1, 32'h400 + i, 32'h4000 + i);
      tick();
      chk_state($sformatf("wrap%0d", i), 3, 0, 0, 0, 0, 0);
    end

    // Reset with count 5, then push+pop on empty
    drive(1, 1, 0, 32'h480, 32'h0, 0, 0); tick();
    drive(1, 1, 0, 32'h484, 32'h0, 0, 0); tick();
    chk_state("pre_rst", 5, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk_state("mid_rst", 0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h500, 32'h99, 1, 0); tick();
    chk_state("rst_pp", 1, 0, 0, 0, 0, 1);
    chk_head("rst_pp", 1, 32'h500, 32'h99);
    drive(1, 0, 0, 0, 0, 1, 0); tick();
    chk_state("rst_pp_pop", 0, 1, 0, 0, 0, 1);

    // Randomized traffic against a queue model
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    mq.delete();
    begin
      logic m_ovf, m_unf;
      int   bias;
      m_ovf = 0; m_unf = 0; bias = 50;
      for (int c = 0; c < 1500; c++) begin
        logic r, p, pw, po, cl, was_full, was_empty;
        logic [31:0] a, d;
        ent_t e, h;
        if (c % 60 == 0) bias = $urandom_range(15, 85);
        r  = ($urandom_range(0, 199) != 0);
        p  = ($urandom_range(0, 99) < bias);
        po = ($urandom_range(0, 99) >= bias);
        if ($urandom_range(0, 3) == 0) begin p = 1; po = 1; end
        pw = $urandom_range(0, 1);
        a  = $urandom; d = $urandom;
        cl = ($urandom_range(0, 15) == 0);
        drive(r, p, pw, a, d, po, cl);
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        #1 chk("rnd.ack", 64'(push_ack_o), 64'(p && !was_full));
        tick();
        if (!r) begin
          mq.delete(); m_ovf = 0; m_unf = 0;
        end else begin
          if (po && !was_empty) void'(mq.pop_front());
          if (p && !was_full) begin
            e.w = pw; e.a = a; e.d = d;
            mq.push_back(e);
          end
          m_ovf = (p && was_full) ? 1'b1 : (cl ? 1'b0 : m_ovf);
          m_unf = (po && was_empty) ? 1'b1 : (cl ? 1'b0 : m_unf);
        end
        chk_state("rnd", mq.size(), mq.size() == 0, mq.size() == D, mq.size() >= AF, m_ovf, m_unf);
        if (mq.size() == 0) chk_head("rnd", 0, 0, 0);
        else begin
          h = mq[0];
          chk_head("rnd", h.w, h.a, h.w ? h.d : 32'h0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_req_fifo_p.md
Name: apb_req_fifo_p

Overview:
Parametrised request FIFO between an APB slave port and the round-robin arbiter. It replaces the fixed 8-deep, 32-bit slave FIFO. Each entry stores the address, the write data and a per-entry write/read flag, so mixed read/write traffic queues correctly. It adds an occupancy count, an almost-full flag, registered full/empty flags and sticky overflow/underflow error flags. Head data is presented first-word-fall-through to the arbiter.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, write-data width in bits
DEPTH, 8, number of entries; power of 2, >= 2
AFULL_LVL, 6, count value at or above which almost_full_o asserts; range 1..DEPTH

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
push_in  in  1  push request from APB slave
push_write_in  in  1  1 = write transfer, 0 = read transfer
push_addr_in  in  ADDR_W  transfer address
push_wdata_in  in  DATA_W  write data; ignored when push_write_in = 0
push_ack_o  out  1  push accepted this cycle
full_o  out  1  FIFO holds DEPTH entries
almost_full_o  out  1  count_o >= AFULL_LVL
pop_in  in  1  pop request from arbiter
pop_valid_o  out  1  head entry valid (equals !empty_o)
pop_write_o  out  1  head entry write flag
pop_addr_o  out  ADDR_W  head entry address
pop_wdata_o  out  DATA_W  head entry write data
empty_o  out  1  FIFO holds 0 entries
count_o  out  $clog2(DEPTH+1)  current occupancy
overflow_o  out  1  sticky flag: push attempted while full
underflow_o  out  1  sticky flag: pop attempted while empty
clr_err_in  in  1  clears overflow_o and underflow_o

Behaviour:
- Reset (reset = 0 at a clk edge):
  - rd_ptr, wr_ptr and count go to 0; empty_o = 1; full_o = 0; almost_full_o = 0.
  - overflow_o = 0; underflow_o = 0.
  - Storage array is not reset.
  - Reset mid-operation discards all queued entries; the first push after reset lands in slot 0.
- Push accept: push_ack_o = push_in & !full_o, combinational. An accepted push writes {push_write_in, push_addr_in, push_wdata_in} at wr_ptr on the clock edge. wr_ptr increments and wraps DEPTH-1 -> 0.
- Pop accept: pop_in & !empty_o. An accepted pop advances rd_ptr, which also wraps DEPTH-1 -> 0.
- Head outputs, combinational from rd_ptr:
  - When empty_o = 1: pop_write_o, pop_addr_o and pop_wdata_o are all 0.
  - pop_wdata_o is forced to 0 whenever the head entry is a read (pop_write_o = 0).
- Latency: a pushed entry is visible on the pop outputs the cycle after its push. There is no same-cycle bypass.
- count_o next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- full_o, empty_o and almost_full_o are registered, derived from the next count value (no combinational path from push_in/pop_in).
- Simultaneous events:
  - Push and pop when 0 < count < DEPTH: both accepted; count unchanged.
  - Push and pop while empty: push accepted, pop refused; count becomes 1; underflow_o sets.
  - Push and pop while full: pop accepted, push refused (push_ack_o = 0); count becomes DEPTH-1; overflow_o sets.
- Error flags:
  - overflow_o sets the cycle after push_in & full_o.
  - underflow_o sets the cycle after pop_in & empty_o.
  - Both flags hold until clr_err_in = 1 (clears next cycle).
  - If a set event and clr_err_in occur in the same cycle, the set wins.
  - Rejected operations never modify pointers, count or storage.
- Read entries consume one slot each; their stored wdata is don't-care and is never driven out.

Test Plan:
1. Reset then idle -> empty_o=1, full_o=0, count_o=0, pop_valid_o=0, all pop data 0, error flags 0.
2. Push 8 writes with addr 0x100+4i and wdata 0xA0+i (DEPTH=8):
   - almost_full_o rises the cycle count_o reaches 6.
   - full_o=1 after the 8th push.
   - A 9th push gives push_ack_o=0 and overflow_o=1 next cycle.
3. Pop all 8 entries from that full FIFO -> addr/wdata appear in order 0x100/0xA0 ... 0x11C/0xA7; empty_o=1 afterwards. A further pop sets underflow_o. Pulse clr_err_in -> both error flags clear.
4. Mixed traffic: push read 0x200, write 0x204/0xDEAD, read 0x208 -> pops give pop_write_o = 0,1,0; pop_wdata_o = 0, 0xDEAD, 0.
5. Wrap-around with simultaneous traffic: hold count at 3 and push+pop every cycle for 20 cycles -> count_o stays 3, FIFO order is preserved across the pointer wrap, no error flags.
6. Corner cases:
   - With count=5, assert reset for one cycle -> count_o=0, empty_o=1.
   - Then push+pop together on the empty FIFO -> count_o=1, underflow_o=1, head = the pushed entry.
